switch_port_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one switch output port between NUM_REQ input requesters in dut_top.
- Grants one requester at a time and holds the grant until that requester's end-of-packet beat is accepted.
- Passes the granted requester's valid/data/last to the output and returns output ready to it.
- Truncates runaway packets at MAX_BEATS beats and counts completed packets.

---
 rtl/switch_arb_pkg.sv | 17 +
 rtl/switch_port_arbiter_if.sv | 26 ++
 rtl/switch_port_arbiter_rr_pick.sv | 29 ++
 rtl/switch_port_arbiter.sv | 90 +++++++++
 tb/tb_switch_port_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/switch_arb_pkg.sv
// rtl/switch_arb_pkg.sv - shared types, defaults and round-robin helper for the switch port arbiter
package switch_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BEATS_DEF = 64;

    function automatic int next_rr_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/switch_port_arbiter_if.sv
// rtl/switch_port_arbiter_if.sv - requester and output-port handshake bundle
interface switch_port_arbiter_if
    import switch_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_last;
    logic                      out_ready;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/switch_port_arbiter_rr_pick.sv
// rtl/switch_port_arbiter_rr_pick.sv - combinational round-robin picker starting after last_gnt
module rr_pick
    import switch_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic               any_req,
    output logic [IDX_W-1:0]   pick_idx
);
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        any_req  = |req;
        pick_idx = '0;
        found    = 1'b0;
        idx      = IDX_W'(next_rr_idx(int'(last_gnt), NUM_REQ));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[idx]) begin
                pick_idx = idx;
                found    = 1'b1;
            end
            idx = IDX_W'(next_rr_idx(int'(idx), NUM_REQ));
        end
    end
endmodule

// File: rtl/switch_port_arbiter.sv
// rtl/switch_port_arbiter.sv - packet-granular round-robin arbiter for one switch output port
module switch_port_arbiter
    import switch_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    switch_port_arbiter_if.slave       bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [15:0]                pkt_count,
    output logic                       trunc_err
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BEATS);

    arb_state_e       state;
    logic [IDX_W-1:0] last_gnt;
    logic [CNT_W-1:0] beat_cnt;
    logic             any_req;
    logic [IDX_W-1:0] pick_idx;
    logic             at_limit;
    logic             accept;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .req      (bus.req_valid),
        .last_gnt (last_gnt),
        .any_req  (any_req),
        .pick_idx (pick_idx)
    );

    assign at_limit = (beat_cnt == CNT_W'(MAX_BEATS - 1));

    // Granted requester is wired straight through; only XFER opens the path.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = bus.req_data[int'(grant_id)*DATA_W +: DATA_W];
        bus.req_ready = '0;
        if (state == XFER) begin
            bus.out_valid           = bus.req_valid[grant_id];
            bus.out_last            = bus.req_last[grant_id] | at_limit;
            bus.req_ready[grant_id] = bus.out_ready;
        end
    end

    assign accept    = bus.out_valid & bus.out_ready;
    assign trunc_err = accept & ~bus.req_last[grant_id] & at_limit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            last_gnt  <= IDX_W'(NUM_REQ - 1);
            beat_cnt  <= '0;
            grant_id  <= '0;
            pkt_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= pick_idx;
                        state    <= XFER;
                        busy     <= 1'b1;
                    end
                end
                XFER: begin
                    if (accept) begin
                        if (bus.out_last) begin
                            beat_cnt  <= '0;
                            last_gnt  <= grant_id;
                            pkt_count <= pkt_count + 16'd1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_switch_port_arbiter.sv
// tb/tb_switch_port_arbiter.sv - directed vector bench for switch_port_arbiter (MAX_BEATS=4)
module tb_switch_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] pkt_count;
    logic        trunc_err;
    int          checks = 0;
    int          failures = 0;

    switch_port_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    switch_port_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .grant_id  (grant_id),
        .busy      (busy),
        .pkt_count (pkt_count),
        .trunc_err (trunc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        rdy;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ol;
        logic [3:0]  e_rr;
        logic [1:0]  e_g;
        logic        e_busy;
        logic [15:0] e_pkt;
        logic        e_trunc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] l, logic [31:0] d, logic rdy,
                                logic e_ov, logic [7:0] e_od, logic e_ol, logic [3:0] e_rr,
                                logic [1:0] e_g, logic e_busy, logic [15:0] e_pkt, logic e_trunc);
        vec_t t;
        t.rst = rst; t.v = v; t.l = l; t.d = d; t.rdy = rdy;
        t.e_ov = e_ov; t.e_od = e_od; t.e_ol = e_ol; t.e_rr = e_rr;
        t.e_g = e_g; t.e_busy = e_busy; t.e_pkt = e_pkt; t.e_trunc = e_trunc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] d, input logic rdy);
        reset         = r;
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc;
        logic       rdy;
        logic [7:0] bd;

        drive(1'b0, 4'b0, 4'b0, 32'h0, 1'b1);

        // single requester 2, three beats
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 32'h0,        1, 0, 8'h00, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h00A10000, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h00A10000, 1, 1, 8'hA1, 0, 4'b0100, 2, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 32'h00A20000, 1, 1, 8'hA2, 0, 4'b0100, 2, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 32'h00A30000, 1, 1, 8'hA3, 1, 4'b0100, 2, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,        1, 0, 8'h00, 0, 4'b0000, 2, 0, 1, 0));
        // all four requesting single-beat packets
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 1, 8'h10, 1, 4'b0001, 0, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 1, 8'h11, 1, 4'b0010, 1, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h00, 0, 4'b0000, 1, 0, 2, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 1, 8'h12, 1, 4'b0100, 2, 1, 2, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h00, 0, 4'b0000, 2, 0, 3, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 1, 8'h13, 1, 4'b1000, 3, 1, 3, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h00, 0, 4'b0000, 3, 0, 4, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 1, 8'h10, 1, 4'b0001, 0, 1, 4, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 5, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 1, 8'h11, 1, 4'b0010, 1, 1, 5, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,        1, 0, 8'h00, 0, 4'b0000, 1, 0, 6, 0));
        // requester 3 runs past MAX_BEATS and is split
        tbl.push_back(mk(1, 4'b1000, 4'b0000, 32'h31000000, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'h31000000, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'h31000000, 1, 1, 8'h31, 0, 4'b1000, 3, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'h32000000, 1, 1, 8'h32, 0, 4'b1000, 3, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'h33000000, 1, 1, 8'h33, 0, 4'b1000, 3, 1, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'h34000000, 1, 1, 8'h34, 1, 4'b1000, 3, 1, 0, 1));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'h35000000, 1, 0, 8'h00, 0, 4'b0000, 3, 0, 1, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 32'h35000000, 1, 1, 8'h35, 0, 4'b1000, 3, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 32'h36000000, 1, 1, 8'h36, 1, 4'b1000, 3, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,        1, 0, 8'h00, 0, 4'b0000, 3, 0, 2, 0));

        foreach (tbl[i]) begin
            drive(~tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), bus.out_valid, tbl[i].e_ov);
            chk($sformatf("v%0d_req_ready", i), bus.req_ready, tbl[i].e_rr);
            chk($sformatf("v%0d_grant_id", i), grant_id, tbl[i].e_g);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d_pkt_count", i), pkt_count, tbl[i].e_pkt);
            chk($sformatf("v%0d_trunc_err", i), trunc_err, tbl[i].e_trunc);
            if (tbl[i].e_ov) begin
                chk($sformatf("v%0d_out_data", i), bus.out_data, tbl[i].e_od);
                chk($sformatf("v%0d_out_last", i), bus.out_last, tbl[i].e_ol);
            end
            tick();
        end

        // requester 1, four beats, out_ready toggling
        drive(1'b0, 4'b0, 4'b0, 32'h0, 1'b1);
        tick();
        drive(1'b1, 4'b0010, 4'b0000, 32'h0000B100, 1'b1);
        @(negedge clk);
        chk("tog_idle_busy", busy, 1'b0);
        tick();
        acc = 0;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            rdy = (c % 2 == 0);
            bd  = 8'hB1 + 8'(acc);
            drive(1'b1, 4'b0010, (acc == 3) ? 4'b0010 : 4'b0000, {16'h0, bd, 8'h00}, rdy);
            @(negedge clk);
            chk("tog_req_ready", bus.req_ready, rdy ? 4'b0010 : 4'b0000);
            if (bus.out_valid && bus.out_ready) begin
                chk("tog_data", bus.out_data, bd);
                chk("tog_last", bus.out_last, acc == 3);
                acc++;
            end
            tick();
        end
        chk("tog_beats", acc, 4);
        drive(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        chk("tog_pkt_count", pkt_count, 16'd1);
        chk("tog_busy_done", busy, 1'b0);
        tick();

        // requester 0 goes quiet mid-packet while requester 1 waits
        drive(1'b0, 4'b0, 4'b0, 32'h0, 1'b1);
        tick();
        drive(1'b1, 4'b0011, 4'b0010, 32'h0000D1C1, 1'b1);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("gap_b1_grant", grant_id, 2'd0);
        chk("gap_b1_data", bus.out_data, 8'hC1);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'b0010, 4'b0010, 32'h0000D1C2, 1'b1);
            @(negedge clk);
            chk("gap_out_valid", bus.out_valid, 1'b0);
            chk("gap_grant", grant_id, 2'd0);
            chk("gap_busy", busy, 1'b1);
            tick();
        end
        drive(1'b1, 4'b0011, 4'b0010, 32'h0000D1C2, 1'b1);
        @(negedge clk);
        chk("gap_b2_data", bus.out_data, 8'hC2);
        chk("gap_b2_valid", bus.out_valid, 1'b1);
        tick();
        drive(1'b1, 4'b0011, 4'b0011, 32'h0000D1C3, 1'b1);
        @(negedge clk);
        chk("gap_b3_last", bus.out_last, 1'b1);
        chk("gap_b3_data", bus.out_data, 8'hC3);
        tick();
        drive(1'b1, 4'b0010, 4'b0010, 32'h0000D100, 1'b1);
        @(negedge clk);
        chk("gap_idle_busy", busy, 1'b0);
        chk("gap_pkt_count", pkt_count, 16'd1);
        tick();
        @(negedge clk);
        chk("gap_next_grant", grant_id, 2'd1);
        chk("gap_next_data", bus.out_data, 8'hD1);
        tick();

        // reset during beat 2 of a requester-2 packet
        drive(1'b0, 4'b0, 4'b0, 32'h0, 1'b1);
        tick();
        drive(1'b1, 4'b0100, 4'b0000, 32'h00E10000, 1'b1);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rst_b1_data", bus.out_data, 8'hE1);
        tick();
        drive(1'b1, 4'b0100, 4'b0000, 32'h00E20000, 1'b1);
        @(negedge clk);
        chk("rst_b2_valid", bus.out_valid, 1'b1);
        bus.req_valid = 4'b0110;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pkt_count", pkt_count, 16'd0);
        chk("rst_grant", grant_id, 2'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rel_busy", busy, 1'b0);
        tick();
        @(negedge clk);
        chk("rst_rel_grant", grant_id, 2'd1);
        chk("rst_rel_busy2", busy, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
